// File: rtl/uart_alu_ctrl_if.sv
// Bundle of UART receive/transmit handshakes and ALU operand/result signals.
// The controller uses the slave view; the surrounding environment drives through master.
interface uart_alu_ctrl_if #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
);
    logic               i_tick;
    logic [NB_DATA-1:0] i_rx_data;
    logic               i_rx_done;
    logic [NB_DATA-1:0] i_alu_result;
    logic               i_tx_done;
    logic [NB_DATA-1:0] o_data_a;
    logic [NB_DATA-1:0] o_data_b;
    logic [NB_OP-1:0]   o_op;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_tx_start;
    logic               o_busy;
    logic               o_drop;
    logic               o_timeout;

    modport slave (
        input  i_tick, i_rx_data, i_rx_done, i_alu_result, i_tx_done,
        output o_data_a, o_data_b, o_op, o_tx_data, o_tx_start, o_busy, o_drop, o_timeout
    );

    modport master (
        output i_tick, i_rx_data, i_rx_done, i_alu_result, i_tx_done,
        input  o_data_a, o_data_b, o_op, o_tx_data, o_tx_start, o_busy, o_drop, o_timeout
    );
endinterface

// File: rtl/uart_alu_ctrl.sv
// Sequences three received bytes (A, B, opcode) into the ALU and one transmit request.
// Latency: opcode byte at n -> o_op at n+1 -> o_tx_start/o_tx_data at n+2.
// Backpressure: none on rx; bytes arriving while a result is pending are dropped and flagged.
module uart_alu_ctrl #(
    parameter int NB_DATA       = 8,
    parameter int NB_OP         = 6,
    parameter int TIMEOUT_TICKS = 1024
) (
    input  logic              clk,
    input  logic              i_rst,
    uart_alu_ctrl_if.slave    bus
);
    localparam int CNT_W = $clog2(TIMEOUT_TICKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_TICKS - 1);

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        CAPTURE = 3'd3,
        WAIT_TX = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] tick_cnt;
    logic             ld_a, ld_b, ld_op, ld_tx;
    logic             drop_nxt, timeout_nxt;
    logic             expire;

    // Expiry only matters in the operand-gathering states; a byte in the same cycle wins.
    assign expire = bus.i_tick && (tick_cnt == CNT_LAST);

    always_comb begin
        state_nxt   = state;
        ld_a        = 1'b0;
        ld_b        = 1'b0;
        ld_op       = 1'b0;
        ld_tx       = 1'b0;
        drop_nxt    = 1'b0;
        timeout_nxt = 1'b0;
        case (state)
            WAIT_A: begin
                if (bus.i_rx_done) begin
                    ld_a      = 1'b1;
                    state_nxt = WAIT_B;
                end
            end
            WAIT_B: begin
                if (bus.i_rx_done) begin
                    ld_b      = 1'b1;
                    state_nxt = WAIT_OP;
                end else if (expire) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = WAIT_A;
                end
            end
            WAIT_OP: begin
                if (bus.i_rx_done) begin
                    ld_op     = 1'b1;
                    state_nxt = CAPTURE;
                end else if (expire) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = WAIT_A;
                end
            end
            CAPTURE: begin
                ld_tx     = 1'b1;
                drop_nxt  = bus.i_rx_done;
                state_nxt = WAIT_TX;
            end
            WAIT_TX: begin
                drop_nxt = bus.i_rx_done;
                if (bus.i_tx_done) begin
                    state_nxt = WAIT_A;
                end
            end
            default: state_nxt = WAIT_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state         <= WAIT_A;
            tick_cnt      <= '0;
            bus.o_data_a  <= '0;
            bus.o_data_b  <= '0;
            bus.o_op      <= '0;
            bus.o_tx_data <= '0;
            bus.o_tx_start <= 1'b0;
            bus.o_drop    <= 1'b0;
            bus.o_timeout <= 1'b0;
        end else begin
            state          <= state_nxt;
            bus.o_tx_start <= ld_tx;
            bus.o_drop     <= drop_nxt;
            bus.o_timeout  <= timeout_nxt;
            if (state_nxt != state) begin
                tick_cnt <= '0;
            end else if (bus.i_tick && (state == WAIT_B || state == WAIT_OP)) begin
                tick_cnt <= tick_cnt + 1'b1;
            end
            if (ld_a)  bus.o_data_a  <= bus.i_rx_data;
            if (ld_b)  bus.o_data_b  <= bus.i_rx_data;
            if (ld_op) bus.o_op      <= bus.i_rx_data[NB_OP-1:0];
            if (ld_tx) bus.o_tx_data <= bus.i_alu_result;
        end
    end

    assign bus.o_busy = (state != WAIT_A);

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Bench for uart_alu_ctrl: vector table of commands plus hand-written timeout, drop and reset sequences.
// Transmit results are predicted into a queue and checked whenever o_tx_start is seen.
module tb_uart_alu_ctrl;
    localparam int NB_DATA = 8;
    localparam int NB_OP   = 6;

    logic clk = 1'b0;
    logic i_rst;
    always #5 clk = ~clk;

    uart_alu_ctrl_if #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) bus ();

    uart_alu_ctrl #(.NB_DATA(NB_DATA), .NB_OP(NB_OP), .TIMEOUT_TICKS(32)) dut (
        .clk   (clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    // Environment ALU driven from the registered operands.
    always_comb begin
        case (bus.o_op)
            6'h20:   bus.i_alu_result = bus.o_data_a + bus.o_data_b;
            6'h22:   bus.i_alu_result = bus.o_data_a - bus.o_data_b;
            6'h24:   bus.i_alu_result = bus.o_data_a & bus.o_data_b;
            6'h25:   bus.i_alu_result = bus.o_data_a | bus.o_data_b;
            6'h26:   bus.i_alu_result = bus.o_data_a ^ bus.o_data_b;
            6'h27:   bus.i_alu_result = ~(bus.o_data_a | bus.o_data_b);
            default: bus.i_alu_result = '0;
        endcase
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op_byte;
        logic [5:0] exp_op;
        logic [7:0] exp_res;
    } vec_t;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (bus.o_tx_start === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_unexpected: got start with data 0x%0h expected no start", bus.o_tx_data);
            end else begin
                chk("sb_tx_data", 32'(bus.o_tx_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.i_rx_data = b;
        bus.i_rx_done = 1'b1;
        step();
        bus.i_rx_done = 1'b0;
    endtask

    task automatic finish_from_op(input logic [7:0] op_byte, input logic [5:0] exp_op,
                                  input logic [7:0] exp_res);
        exp_q.push_back(exp_res);
        send_byte(op_byte);
        chk("op_reg", 32'(bus.o_op), 32'(exp_op));
        chk("start_in_capture", 32'(bus.o_tx_start), 0);
        step();
        chk("start_pulse", 32'(bus.o_tx_start), 1);
        chk("tx_data", 32'(bus.o_tx_data), 32'(exp_res));
        step();
        chk("start_single", 32'(bus.o_tx_start), 0);
        step();
        chk("busy_wait_tx", 32'(bus.o_busy), 1);
        bus.i_tx_done = 1'b1;
        step();
        bus.i_tx_done = 1'b0;
        chk("busy_after_done", 32'(bus.o_busy), 0);
        chk("tx_data_held", 32'(bus.o_tx_data), 32'(exp_res));
    endtask

    task automatic run_cmd(input vec_t v);
        send_byte(v.a);
        chk("busy_after_a", 32'(bus.o_busy), 1);
        send_byte(v.b);
        chk("data_a", 32'(bus.o_data_a), 32'(v.a));
        chk("data_b", 32'(bus.o_data_b), 32'(v.b));
        finish_from_op(v.op_byte, v.exp_op, v.exp_res);
    endtask

    vec_t vecs[9];
    vec_t v;

    initial begin
        vecs[0] = '{8'h05, 8'h03, 8'h20, 6'h20, 8'h08};
        vecs[1] = '{8'hFF, 8'h01, 8'h20, 6'h20, 8'h00};
        vecs[2] = '{8'h0A, 8'h03, 8'h22, 6'h22, 8'h07};
        vecs[3] = '{8'h03, 8'h05, 8'h22, 6'h22, 8'hFE};
        vecs[4] = '{8'hF0, 8'h3C, 8'h24, 6'h24, 8'h30};
        vecs[5] = '{8'hF0, 8'h0F, 8'h25, 6'h25, 8'hFF};
        vecs[6] = '{8'hAA, 8'hFF, 8'h26, 6'h26, 8'h55};
        vecs[7] = '{8'h0F, 8'hF0, 8'h27, 6'h27, 8'h00};
        vecs[8] = '{8'h12, 8'h34, 8'hE0, 6'h20, 8'h46};

        i_rst = 1'b1;
        bus.i_tick = 1'b0;
        bus.i_rx_data = '0;
        bus.i_rx_done = 1'b0;
        bus.i_tx_done = 1'b0;
        step();
        step();
        i_rst = 1'b0;
        chk("rst_data_a", 32'(bus.o_data_a), 0);
        chk("rst_op", 32'(bus.o_op), 0);
        chk("rst_tx_data", 32'(bus.o_tx_data), 0);
        chk("rst_busy", 32'(bus.o_busy), 0);
        chk("rst_start", 32'(bus.o_tx_start), 0);

        for (int i = 0; i < 9; i++) run_cmd(vecs[i]);

        // tx_done outside WAIT_TX must not disturb a command in progress.
        send_byte(8'h21);
        bus.i_tx_done = 1'b1;
        step();
        bus.i_tx_done = 1'b0;
        chk("txdone_ignored_busy", 32'(bus.o_busy), 1);
        send_byte(8'h02);
        finish_from_op(8'h20, 6'h20, 8'h23);

        // Timeout after 32 ticks in WAIT_B.
        send_byte(8'h11);
        bus.i_tick = 1'b1;
        for (int i = 0; i < 31; i++) begin
            step();
            chk("no_early_timeout", 32'(bus.o_timeout), 0);
        end
        step();
        bus.i_tick = 1'b0;
        chk("timeout_pulse", 32'(bus.o_timeout), 1);
        chk("timeout_busy", 32'(bus.o_busy), 0);
        chk("timeout_stale_a", 32'(bus.o_data_a), 32'h11);
        step();
        chk("timeout_single", 32'(bus.o_timeout), 0);
        v = '{8'h01, 8'h02, 8'h20, 6'h20, 8'h03};
        run_cmd(v);

        // Byte on the same cycle as the expiring tick wins.
        send_byte(8'h11);
        bus.i_tick = 1'b1;
        for (int i = 0; i < 31; i++) step();
        send_byte(8'h22);
        bus.i_tick = 1'b0;
        chk("race_no_timeout", 32'(bus.o_timeout), 0);
        chk("race_data_b", 32'(bus.o_data_b), 32'h22);
        chk("race_busy", 32'(bus.o_busy), 1);
        finish_from_op(8'h20, 6'h20, 8'h33);

        // Byte during WAIT_TX is dropped.
        send_byte(8'h44);
        send_byte(8'h10);
        exp_q.push_back(8'h54);
        send_byte(8'h20);
        step();
        send_byte(8'h7F);
        chk("drop_pulse", 32'(bus.o_drop), 1);
        chk("drop_keeps_a", 32'(bus.o_data_a), 32'h44);
        step();
        chk("drop_single", 32'(bus.o_drop), 0);
        chk("drop_still_busy", 32'(bus.o_busy), 1);
        bus.i_tx_done = 1'b1;
        step();
        bus.i_tx_done = 1'b0;
        chk("drop_then_idle", 32'(bus.o_busy), 0);

        // Reset while waiting for the opcode.
        send_byte(8'h55);
        send_byte(8'h66);
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        chk("mid_rst_a", 32'(bus.o_data_a), 0);
        chk("mid_rst_b", 32'(bus.o_data_b), 0);
        chk("mid_rst_op", 32'(bus.o_op), 0);
        chk("mid_rst_tx", 32'(bus.o_tx_data), 0);
        chk("mid_rst_busy", 32'(bus.o_busy), 0);
        chk("mid_rst_flags", 32'({bus.o_tx_start, bus.o_drop, bus.o_timeout}), 0);
        v = '{8'h09, 8'h04, 8'h22, 6'h22, 8'h05};
        run_cmd(v);

        // tx_done and rx_done together in WAIT_TX.
        send_byte(8'h01);
        send_byte(8'h01);
        exp_q.push_back(8'h02);
        send_byte(8'h20);
        step();
        bus.i_tx_done = 1'b1;
        send_byte(8'h99);
        bus.i_tx_done = 1'b0;
        chk("both_drop", 32'(bus.o_drop), 1);
        chk("both_idle", 32'(bus.o_busy), 0);
        step();
        step();
        chk("both_stays_idle", 32'(bus.o_busy), 0);
        chk("both_a_kept", 32'(bus.o_data_a), 32'h01);
        v = '{8'h40, 8'h02, 8'h22, 6'h22, 8'h3E};
        run_cmd(v);

        step();
        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_alu_ctrl.md
# uart_alu_ctrl

Sequencing controller between the UART receiver, the ALU and the UART transmitter. Collects three received bytes (operand A, operand B, opcode), presents them as registered ALU inputs, captures the ALU result, and issues a single transmit request with a handshake back from the transmitter. An inter-byte timeout, counted in baud oversampling ticks, discards incomplete commands.

## Interface
- NB_DATA, 8, width of UART data and ALU operands/result
- NB_OP, 6, ALU opcode width; taken from the low NB_OP bits of the third byte (NB_OP ≤ NB_DATA)
- TIMEOUT_TICKS, 1024, i_tick pulses allowed between bytes of one command (≥ 2)

- clk  input  1  system clock; all logic on rising edge
- i_rst  input  1  synchronous, active-high reset
- i_tick  input  1  baud-generator oversampling tick, one-cycle pulse
- i_rx_data  input  NB_DATA  received byte, valid when i_rx_done = 1
- i_rx_done  input  1  one-cycle pulse: byte received
- i_alu_result  input  NB_DATA  combinational ALU output from o_data_a/o_data_b/o_op
- i_tx_done  input  1  one-cycle pulse: transmitter finished its frame
- o_data_a  output  NB_DATA  registered operand A
- o_data_b  output  NB_DATA  registered operand B
- o_op  output  NB_OP  registered opcode
- o_tx_data  output  NB_DATA  byte to transmit; held stable until the next command's capture
- o_tx_start  output  1  one-cycle transmit request
- o_busy  output  1  high in every state except WAIT_A
- o_drop  output  1  one-cycle pulse: a received byte was ignored
- o_timeout  output  1  one-cycle pulse: incomplete command discarded

## Operation
- States: WAIT_A, WAIT_B, WAIT_OP, CAPTURE, WAIT_TX. Binary encoded, registered.
- WAIT_A: on i_rx_done, o_data_a <= i_rx_data, clear tick counter, go to WAIT_B.
- WAIT_B: on i_rx_done, o_data_b <= i_rx_data, clear counter, go to WAIT_OP.
- WAIT_OP: on i_rx_done, o_op <= i_rx_data[NB_OP-1:0], go to CAPTURE.
- CAPTURE (exactly one cycle): operands stable, ALU settles; at the end of the cycle o_tx_data <= i_alu_result, o_tx_start <= 1, go to WAIT_TX.
- WAIT_TX: o_tx_start low after its single cycle; stay until i_tx_done, then go to WAIT_A.
- Timeout: tick counter is $clog2(TIMEOUT_TICKS) bits, increments on i_tick only in WAIT_B/WAIT_OP, cleared on entering any state. When the counter equals TIMEOUT_TICKS-1 and i_tick = 1 with no i_rx_done: go to WAIT_A, pulse o_timeout. o_data_a/o_data_b keep stale values; o_op is not modified.
- Drop: i_rx_done in CAPTURE or WAIT_TX → o_drop pulses the next cycle; byte ignored; state unaffected.
- Simultaneous events: i_rx_done beats timeout expiry in the same cycle (byte accepted, no o_timeout). i_tx_done and i_rx_done together in WAIT_TX → go to WAIT_A, byte dropped (o_drop), not taken as operand A.
- i_tx_done outside WAIT_TX is ignored.
- Reset: from any state, the cycle after i_rst is sampled high, state = WAIT_A, all outputs 0, counter 0. Any command in progress is lost without o_timeout or o_drop.

## Timing
- Reset values: o_data_a, o_data_b, o_op, o_tx_data = 0. o_tx_start, o_busy, o_drop, o_timeout = 0.
- Opcode pulse at cycle n (i_rx_done in WAIT_OP) → o_op valid at n+1 (CAPTURE) → o_tx_data valid and o_tx_start high at n+2, for exactly one cycle.
- o_busy goes high the cycle after operand A is accepted. It drops the cycle after i_tx_done in WAIT_TX.
- o_drop and o_timeout are registered; they assert one cycle after the causing event.
- New command accepted at the earliest one cycle after i_tx_done.

## Test plan
- Reset then bytes 0x05, 0x03, 0x20, with the ALU modelled as add → o_op = 6'h20 one cycle after the third pulse; o_tx_data = 0x08 and o_tx_start high one cycle later, for one cycle; o_busy drops the cycle after i_tx_done.
- TIMEOUT_TICKS = 32; send 0x11, then issue 32 ticks with no byte → o_timeout pulses once, o_busy = 0; next bytes 0x01, 0x02, 0x20 complete normally with A = 0x01.
- Byte arriving on the same cycle as the 32nd tick in WAIT_B → accepted as B, no o_timeout.
- i_rx_done (0x7F) during WAIT_TX → o_drop pulses once; o_data_a unchanged; state still WAIT_TX until i_tx_done.
- Assert i_rst for one cycle while in WAIT_OP → next cycle all outputs 0 and state WAIT_A; a following three-byte command completes normally.
- i_tx_done and i_rx_done in the same cycle in WAIT_TX → o_drop pulses, state returns to WAIT_A, o_busy stays 0 until the next byte.
